ahb_gpu_cmd_queue: RTL

- AHB-Lite slave that queues draw commands for the SDRAM/HDMI display engine, so the CPU can post several commands without polling busy between them.
- CPU writes X/Y/PIXEL/LEN into staging registers, then writes PUSH to enqueue the 4-tuple into a parametrised FIFO.
- Queue drains to the engine over a valid/ready handshake.
- Sits between the AHB-Lite bus matrix and the display engine.

---
 rtl/ahb_gpu_pkg.sv | 33 +++
 rtl/ahb_gpu_cmd_queue_if.sv | 19 +
 rtl/ahb_gpu_sync_fifo.sv | 53 +++++
 rtl/ahb_gpu_cmd_queue.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ahb_gpu_pkg.sv
// Shared constants for the GPU draw-command queue: register map, CTRL/STATUS
// bit positions and default command-entry field widths.
package ahb_gpu_pkg;
  localparam logic [7:0] OFS_X          = 8'h00;
  localparam logic [7:0] OFS_Y          = 8'h04;
  localparam logic [7:0] OFS_PIXEL      = 8'h08;
  localparam logic [7:0] OFS_LEN        = 8'h0C;
  localparam logic [7:0] OFS_PUSH       = 8'h10;
  localparam logic [7:0] OFS_CTRL       = 8'h14;
  localparam logic [7:0] OFS_STATUS     = 8'h18;
  localparam logic [7:0] OFS_SYS_WR_LEN = 8'h1C;
  localparam logic [7:0] OFS_OVF_CLR    = 8'h20;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_BUSY  = 3;
  localparam int ST_SYSV  = 4;
  localparam int ST_CNT   = 8;

  localparam int COORD_W_DEF = 16;
  localparam int PIXEL_W_DEF = 24;
  localparam int LEN_W_DEF   = 24;
  localparam int CMD_W       = 2*COORD_W_DEF + PIXEL_W_DEF + LEN_W_DEF;

  function automatic int cmd_width(int cw, int pw, int lw);
    return 2*cw + pw + lw;
  endfunction
endpackage

// File: rtl/ahb_gpu_cmd_queue_if.sv
// AHB-Lite slave-side signal bundle for the command queue.
interface ahb_gpu_cmd_queue_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
                  input  HREADYOUT, HRDATA, HRESP);
  modport slave  (input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
                  output HREADYOUT, HRDATA, HRESP);
endinterface

// File: rtl/ahb_gpu_sync_fifo.sv
// Show-ahead synchronous FIFO; flush overrides same-cycle push/pop.
module ahb_gpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        wr_ok, rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];
  // When full, a write is only legal because the head slot frees at the same edge.
  assign wr_ok = push & (~full | pop);
  assign rd_ok = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ahb_gpu_cmd_queue.sv
// AHB-Lite register front end that stages draw commands and queues them
// for the display engine over a valid/ready handshake.
module ahb_gpu_cmd_queue
  import ahb_gpu_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int COORD_W = COORD_W_DEF,
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int WRLEN_W = 9
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_gpu_cmd_queue_if.slave   ahb,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [COORD_W-1:0]   cmd_x,
  output logic [COORD_W-1:0]   cmd_y,
  output logic [PIXEL_W-1:0]   cmd_pixel,
  output logic [LEN_W-1:0]     cmd_len,
  output logic [WRLEN_W-1:0]   sys_wr_len,
  input  logic                 eng_busy,
  input  logic                 eng_sys_valid,
  output logic                 irq
);
  localparam int ENTRY_W = cmd_width(COORD_W, PIXEL_W, LEN_W);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic               dp_vld, dp_write;
  logic [7:0]         dp_addr;
  logic [COORD_W-1:0] x_q, y_q;
  logic [PIXEL_W-1:0] pixel_q;
  logic [LEN_W-1:0]   len_q;
  logic [1:0]         ctrl_q;
  logic               ovf_q;
  logic               wr_en, rd_en, push, pop, flush, ovf_clr;
  logic               full, empty;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;
  logic [31:0]        status, rdata;
  logic               unused;

  assign unused = ^{ahb.HSIZE, ahb.HPROT, ahb.HADDR[31:8], ahb.HWDATA};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_vld   <= 1'b0;
      dp_addr  <= '0;
      dp_write <= 1'b0;
    end else if (ahb.HREADY) begin
      dp_vld   <= ahb.HSEL & ahb.HTRANS[1];
      dp_addr  <= ahb.HADDR[7:0];
      dp_write <= ahb.HWRITE;
    end
  end

  assign wr_en   = dp_vld & dp_write;
  assign rd_en   = dp_vld & ~dp_write;
  assign push    = wr_en & (dp_addr == OFS_PUSH);
  assign flush   = wr_en & (dp_addr == OFS_CTRL) & ahb.HWDATA[CTRL_FLUSH];
  assign ovf_clr = wr_en & (dp_addr == OFS_OVF_CLR) & ahb.HWDATA[0];
  assign cmd_valid = ~empty & ctrl_q[CTRL_ENABLE];
  assign pop       = cmd_valid & cmd_ready;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      x_q        <= '0;
      y_q        <= '0;
      pixel_q    <= '0;
      len_q      <= '0;
      ctrl_q     <= '0;
      sys_wr_len <= '0;
      ovf_q      <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_en) begin
        case (dp_addr)
          OFS_X:          x_q        <= ahb.HWDATA[COORD_W-1:0];
          OFS_Y:          y_q        <= ahb.HWDATA[COORD_W-1:0];
          OFS_PIXEL:      pixel_q    <= ahb.HWDATA[PIXEL_W-1:0];
          OFS_LEN:        len_q      <= ahb.HWDATA[LEN_W-1:0];
          OFS_CTRL:       ctrl_q     <= {ahb.HWDATA[CTRL_IRQ_EN], ahb.HWDATA[CTRL_ENABLE]};
          OFS_SYS_WR_LEN: sys_wr_len <= ahb.HWDATA[WRLEN_W-1:0];
          default: ;
        endcase
      end
      // A fresh overflow beats a same-cycle clear.
      if (push & full & ~pop) ovf_q <= 1'b1;
      else if (ovf_clr)       ovf_q <= 1'b0;
      irq <= ctrl_q[CTRL_IRQ_EN] & empty & ~eng_busy;
    end
  end

  ahb_gpu_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .flush (flush),
    .push  (push),
    .wdata ({x_q, y_q, pixel_q, len_q}),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign {cmd_x, cmd_y, cmd_pixel, cmd_len} = head;

  always_comb begin
    status           = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
    status[ST_OVF]   = ovf_q;
    status[ST_BUSY]  = eng_busy;
    status[ST_SYSV]  = eng_sys_valid;
    status[ST_CNT +: CNT_W] = count;
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (dp_addr)
        OFS_X:          rdata[COORD_W-1:0] = x_q;
        OFS_Y:          rdata[COORD_W-1:0] = y_q;
        OFS_PIXEL:      rdata[PIXEL_W-1:0] = pixel_q;
        OFS_LEN:        rdata[LEN_W-1:0]   = len_q;
        OFS_CTRL:       rdata[1:0]         = ctrl_q;
        OFS_STATUS:     rdata              = status;
        OFS_SYS_WR_LEN: rdata[WRLEN_W-1:0] = sys_wr_len;
        default: ;
      endcase
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
endmodule
